// File: rtl/dom_gf4_share_encoder_if.sv
// dom_gf4_share_encoder_if: handshake and share buses of dom_gf4_share_encoder
//   master: producer/consumer side (SeedValidxSI, SeedxDI, InValidxSI, X1xDI..X4xDI, YxDI, OutReadyxSI)
//   slave : encoder side (InReadyxSO, OutValidxSO, _X1xDO.._X4xDO, _YxDO, _Z1xDO.._Z4xDO, _BxDO)
//   ErrxSO exists only when DOM_ENC_UNMASK_CHECK_EN is defined
interface dom_gf4_share_encoder_if #(
  parameter int SHARES = 2,
  parameter int FIRST_ORDER_OPTIMIZATION = 1
);
  localparam int BLIND_NRND = (FIRST_ORDER_OPTIMIZATION == 1 && SHARES == 2) ? 1 : SHARES;
  logic SeedValidxSI;
  logic [31:0] SeedxDI;
  logic InValidxSI;
  logic InReadyxSO;
  logic [1:0] X1xDI, X2xDI, X3xDI, X4xDI, YxDI;
  logic OutValidxSO;
  logic OutReadyxSI;
  logic [2*SHARES-1:0] _X1xDO, _X2xDO, _X3xDO, _X4xDO, _YxDO;
  logic [SHARES*(SHARES-1)-1:0] _Z1xDO, _Z2xDO, _Z3xDO, _Z4xDO;
  logic [2*BLIND_NRND-1:0] _BxDO;
`ifdef DOM_ENC_UNMASK_CHECK_EN
  logic ErrxSO;
`endif
  modport master (
    output SeedValidxSI, SeedxDI, InValidxSI, X1xDI, X2xDI, X3xDI, X4xDI, YxDI, OutReadyxSI,
    input InReadyxSO, OutValidxSO, _X1xDO, _X2xDO, _X3xDO, _X4xDO, _YxDO,
    input _Z1xDO, _Z2xDO, _Z3xDO, _Z4xDO, _BxDO
`ifdef DOM_ENC_UNMASK_CHECK_EN
    , input ErrxSO
`endif
  );
  modport slave (
    input SeedValidxSI, SeedxDI, InValidxSI, X1xDI, X2xDI, X3xDI, X4xDI, YxDI, OutReadyxSI,
    output InReadyxSO, OutValidxSO, _X1xDO, _X2xDO, _X3xDO, _X4xDO, _YxDO,
    output _Z1xDO, _Z2xDO, _Z3xDO, _Z4xDO, _BxDO
`ifdef DOM_ENC_UNMASK_CHECK_EN
    , output ErrxSO
`endif
  );
endinterface

// File: rtl/dom_gf4_share_encoder.sv
// dom_gf4_share_encoder: splits GF(2^2) X1..X4/Y operands into Boolean shares and adds fresh Z/B randomness
//   ClkxCI, RstxRI (sync, active-high); bus (slave modport of dom_gf4_share_encoder_if)
//   optional macro DOM_ENC_UNMASK_CHECK_EN adds sticky recombination-error flag bus.ErrxSO
module dom_gf4_share_encoder #(
  parameter int SHARES = 2,
  parameter int FIRST_ORDER_OPTIMIZATION = 1,
  parameter int WARMUP = 64,
  parameter logic [31:0] SEED_DEFAULT = 32'hACE1_2468
) (
  input logic ClkxCI,
  input logic RstxRI,
  dom_gf4_share_encoder_if.slave bus
);
  localparam int BN = (FIRST_ORDER_OPTIMIZATION == 1 && SHARES == 2) ? 1 : SHARES;
  localparam int M = 2*(SHARES-1);
  localparam int W = 2*SHARES;
  localparam int ZW = SHARES*(SHARES-1);
  localparam int NR = 5*M + 4*ZW + 2*BN;
  localparam int CW = WARMUP > 0 ? $clog2(WARMUP+1) : 1;
  localparam logic [CW-1:0] LAST = CW'(WARMUP > 0 ? WARMUP-1 : 0);
  typedef enum logic {WARM, RUN} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [31:0] prng, prng_adv;
  logic [NR-1:0] rnd;
  logic in_ready, accept, out_valid;
  logic [4:0][1:0] plain;
  logic [4:0][W-1:0] share_d, share_q;
  logic [3:0][ZW-1:0] z_q;
  logic [2*BN-1:0] b_q;
  function automatic logic [W-1:0] share(input logic [1:0] v, input logic [M-1:0] r);
    logic [W-1:0] s;
    logic [1:0] acc;
    s = '0;
    acc = v;
    for (int m = 0; m < SHARES-1; m++) begin
      s[2*m +: 2] = r[2*m +: 2];
      acc = acc ^ r[2*m +: 2];
    end
    s[W-2 +: 2] = acc;
    return s;
  endfunction
  assign plain = {bus.YxDI, bus.X4xDI, bus.X3xDI, bus.X2xDI, bus.X1xDI};
  assign in_ready = state == RUN && !bus.SeedValidxSI && (!out_valid || bus.OutReadyxSI);
  assign accept = bus.InValidxSI && in_ready;
  // NR Galois steps per advance; rnd[k] is the k-th output bit
  always_comb begin
    prng_adv = prng;
    rnd = '0;
    share_d = '0;
    for (int k = 0; k < NR; k++) begin
      rnd[k] = prng_adv[0];
      prng_adv = prng_adv[0] ? (prng_adv >> 1) ^ 32'h8020_0003 : prng_adv >> 1;
    end
    for (int i = 0; i < 5; i++) share_d[i] = share(plain[i], rnd[i*M +: M]);
  end
  always_ff @(posedge ClkxCI) begin
    if (RstxRI) begin
      prng <= SEED_DEFAULT;
      state <= WARM;
      cnt <= '0;
      out_valid <= 1'b0;
      share_q <= '0;
      z_q <= '0;
      b_q <= '0;
    end else if (bus.SeedValidxSI) begin
      prng <= bus.SeedxDI == '0 ? 32'h1 : bus.SeedxDI;
      state <= WARM;
      cnt <= '0;
      out_valid <= 1'b0;
    end else begin
      if (state == WARM) begin
        prng <= prng_adv;
        cnt <= cnt + CW'(1);
        state <= cnt == LAST ? RUN : WARM;
      end else if (accept) prng <= prng_adv;
      if (accept) begin
        share_q <= share_d;
        z_q <= rnd[5*M +: 4*ZW];
        b_q <= rnd[5*M+4*ZW +: 2*BN];
        out_valid <= 1'b1;
      end else if (bus.OutReadyxSI) out_valid <= 1'b0;
    end
  end
  assign bus.InReadyxSO = in_ready;
  assign bus.OutValidxSO = out_valid;
  assign bus._X1xDO = share_q[0];
  assign bus._X2xDO = share_q[1];
  assign bus._X3xDO = share_q[2];
  assign bus._X4xDO = share_q[3];
  assign bus._YxDO = share_q[4];
  assign bus._Z1xDO = z_q[0];
  assign bus._Z2xDO = z_q[1];
  assign bus._Z3xDO = z_q[2];
  assign bus._Z4xDO = z_q[3];
  assign bus._BxDO = b_q;
`ifdef DOM_ENC_UNMASK_CHECK_EN
  logic [4:0][1:0] plain_q;
  logic err, bad;
  function automatic logic [1:0] fold(input logic [W-1:0] s);
    logic [1:0] r;
    r = '0;
    for (int k = 0; k < SHARES; k++) r = r ^ s[2*k +: 2];
    return r;
  endfunction
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < 5; i++) bad = bad | (fold(share_q[i]) != plain_q[i]);
  end
  always_ff @(posedge ClkxCI) begin
    if (RstxRI) begin
      plain_q <= '0;
      err <= 1'b0;
    end else begin
      if (accept) plain_q <= plain;
      if (out_valid && bad) err <= 1'b1;
    end
  end
  assign bus.ErrxSO = err;
`endif
endmodule

// File: tb/tb_dom_gf4_share_encoder.sv
// tb_dom_gf4_share_encoder: randomized self-checking bench against a bit-serial LFSR reference model
module tb_dom_gf4_share_encoder;
  localparam logic [31:0] MASK = 32'h8020_0003;
  localparam logic [31:0] SEED_DEF = 32'hACE1_2468;
  typedef logic [9:0][63:0] vec_t;
  typedef logic [4:0][1:0] ops_t;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  dom_gf4_share_encoder_if #(.SHARES(2)) if2 ();
  dom_gf4_share_encoder_if #(.SHARES(3)) if3 ();
  dom_gf4_share_encoder #(.SHARES(2)) dut2 (.ClkxCI(clk), .RstxRI(rst), .bus(if2));
  dom_gf4_share_encoder #(.SHARES(3), .WARMUP(4)) dut3 (.ClkxCI(clk), .RstxRI(rst), .bus(if3));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  function automatic int bn(input int s);
    return s == 2 ? 1 : s;
  endfunction
  function automatic int nr(input int s);
    return 10*(s-1) + 4*s*(s-1) + 2*bn(s);
  endfunction
  function automatic logic [31:0] adv(input logic [31:0] st, input int n, output logic [63:0] b);
    logic [31:0] s = st;
    b = '0;
    for (int k = 0; k < n; k++) begin
      b[k] = s[0];
      s = s[0] ? (s >> 1) ^ MASK : s >> 1;
    end
    return s;
  endfunction
  function automatic logic [31:0] warm(input logic [31:0] st, input int n, input int cycles);
    logic [31:0] s = st;
    logic [63:0] b;
    for (int c = 0; c < cycles; c++) s = adv(s, n, b);
    return s;
  endfunction
  function automatic logic [63:0] field(input logic [63:0] b, input int off, input int n);
    return (b >> off) & ((64'd1 << n) - 64'd1);
  endfunction
  function automatic logic [63:0] share(input logic [1:0] v, input logic [63:0] b, input int off, input int s);
    logic [63:0] r = '0;
    logic [1:0] acc = v;
    logic [1:0] m;
    for (int k = 0; k < s-1; k++) begin
      m = 2'(field(b, off + 2*k, 2));
      r = r | (64'(m) << (2*k));
      acc = acc ^ m;
    end
    return r | (64'(acc) << (2*(s-1)));
  endfunction
  function automatic vec_t model_out(input ops_t v, input logic [63:0] b, input int s);
    vec_t e;
    int m = 2*(s-1);
    int zw = s*(s-1);
    for (int i = 0; i < 5; i++) e[i] = share(v[i], b, i*m, s);
    for (int i = 0; i < 4; i++) e[5+i] = field(b, 5*m + i*zw, zw);
    e[9] = field(b, 5*m + 4*zw, 2*bn(s));
    return e;
  endfunction
  function automatic logic [1:0] fold(input logic [63:0] x, input int s);
    logic [1:0] r = '0;
    for (int k = 0; k < s; k++) r = r ^ 2'(x >> (2*k));
    return r;
  endfunction
  function automatic vec_t obs2();
    vec_t o;
    o = {64'(if2._BxDO), 64'(if2._Z4xDO), 64'(if2._Z3xDO), 64'(if2._Z2xDO), 64'(if2._Z1xDO),
         64'(if2._YxDO), 64'(if2._X4xDO), 64'(if2._X3xDO), 64'(if2._X2xDO), 64'(if2._X1xDO)};
    return o;
  endfunction
  function automatic vec_t obs3();
    vec_t o;
    o = {64'(if3._BxDO), 64'(if3._Z4xDO), 64'(if3._Z3xDO), 64'(if3._Z2xDO), 64'(if3._Z1xDO),
         64'(if3._YxDO), 64'(if3._X4xDO), 64'(if3._X3xDO), 64'(if3._X2xDO), 64'(if3._X1xDO)};
    return o;
  endfunction
  task automatic check_vec(input string tag, input vec_t got, input vec_t exp, input ops_t v, input int s);
    for (int i = 0; i < 10; i++) check($sformatf("%s_bus%0d", tag, i), got[i], exp[i]);
    for (int i = 0; i < 5; i++) check($sformatf("%s_fold%0d", tag, i), 64'(fold(got[i], s)), 64'(v[i]));
  endtask
  task automatic drive2(input ops_t v);
    {if2.YxDI, if2.X4xDI, if2.X3xDI, if2.X2xDI, if2.X1xDI} = v;
  endtask
  task automatic drive3(input ops_t v);
    {if3.YxDI, if3.X4xDI, if3.X3xDI, if3.X2xDI, if3.X1xDI} = v;
  endtask
  task automatic wait_ready2(output int n);
    n = 0;
    while (!if2.InReadyxSO && n < 200) begin
      step();
      n++;
    end
  endtask
  initial begin
    logic [31:0] m2, m3;
    logic [63:0] b;
    vec_t e2, e3;
    ops_t v, pv2, pv3, first;
    int n;
    bit iv, ordy, mrdy, m_ov3;
    rst = 1'b1;
    if2.SeedValidxSI = 1'b0; if2.SeedxDI = '0; if2.InValidxSI = 1'b0; if2.OutReadyxSI = 1'b0; drive2('0);
    if3.SeedValidxSI = 1'b0; if3.SeedxDI = '0; if3.InValidxSI = 1'b0; if3.OutReadyxSI = 1'b0; drive3('0);
    repeat (3) step();
    check("rst_rdy2", 64'(if2.InReadyxSO), 64'd0);
    check("rst_ov2", 64'(if2.OutValidxSO), 64'd0);
    check("rst_rdy3", 64'(if3.InReadyxSO), 64'd0);
    check("rst_ov3", 64'(if3.OutValidxSO), 64'd0);
    e2 = obs2();
    e3 = obs3();
    for (int i = 0; i < 10; i++) begin
      check($sformatf("rst_bus2_%0d", i), e2[i], 64'd0);
      check($sformatf("rst_bus3_%0d", i), e3[i], 64'd0);
    end
    rst = 1'b0;
    wait_ready2(n);
    check("warm_len", 64'(n), 64'd64);
    m2 = warm(SEED_DEF, nr(2), 64);
    m3 = warm(SEED_DEF, nr(3), 4);
    // reseed with a competing input beat: the beat must be refused
    if2.SeedValidxSI = 1'b1; if2.SeedxDI = 32'h1; if2.InValidxSI = 1'b1; if2.OutReadyxSI = 1'b1;
    drive2(10'($urandom));
    #1;
    check("seed_rdy", 64'(if2.InReadyxSO), 64'd0);
    step();
    if2.SeedValidxSI = 1'b0; if2.InValidxSI = 1'b0;
    check("seed_ov", 64'(if2.OutValidxSO), 64'd0);
    m2 = warm(32'h1, nr(2), 64);
    wait_ready2(n);
    check("rewarm_len", 64'(n), 64'd64);
    first = {2'd2, 2'd3, 2'd2, 2'd1, 2'd0};
    drive2(first); if2.InValidxSI = 1'b1; if2.OutReadyxSI = 1'b1;
    #1;
    check("t1_rdy", 64'(if2.InReadyxSO), 64'd1);
    m2 = adv(m2, nr(2), b);
    e2 = model_out(first, b, 2);
    pv2 = first;
    step();
    check("t1_ov", 64'(if2.OutValidxSO), 64'd1);
    check_vec("t1", obs2(), e2, pv2, 2);
    check("t1_x1lsb", 64'(if2._X1xDO[1:0]), field(b, 0, 2));
    // stall: output must hold, input refused, PRNG frozen
    drive2(10'($urandom)); if2.InValidxSI = 1'b1; if2.OutReadyxSI = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("hold_rdy", 64'(if2.InReadyxSO), 64'd0);
      step();
      check("hold_ov", 64'(if2.OutValidxSO), 64'd1);
      check_vec("hold", obs2(), e2, pv2, 2);
    end
    for (int c = 0; c < 8; c++) begin
      v = 10'($urandom);
      drive2(v); if2.InValidxSI = 1'b1; if2.OutReadyxSI = 1'b1;
      #1;
      check("b2b_rdy", 64'(if2.InReadyxSO), 64'd1);
      m2 = adv(m2, nr(2), b);
      e2 = model_out(v, b, 2);
      pv2 = v;
      step();
      check("b2b_ov", 64'(if2.OutValidxSO), 64'd1);
      check_vec("b2b", obs2(), e2, pv2, 2);
    end
    // zero seed while an output is held
    if2.OutReadyxSI = 1'b0; if2.InValidxSI = 1'b1; if2.SeedValidxSI = 1'b1; if2.SeedxDI = 32'h0;
    step();
    if2.SeedValidxSI = 1'b0; if2.InValidxSI = 1'b0;
    check("drop_ov", 64'(if2.OutValidxSO), 64'd0);
    m2 = warm(32'h1, nr(2), 64);
    wait_ready2(n);
    check("zseed_warm_len", 64'(n), 64'd64);
    drive2(first); if2.InValidxSI = 1'b1; if2.OutReadyxSI = 1'b1;
    m2 = adv(m2, nr(2), b);
    e2 = model_out(first, b, 2);
    step();
    if2.InValidxSI = 1'b0; if2.OutReadyxSI = 1'b0;
    check("zseed_ov", 64'(if2.OutValidxSO), 64'd1);
    check_vec("zseed", obs2(), e2, first, 2);
    // SHARES=3 random traffic with scoreboard
    m_ov3 = 1'b0;
    pv3 = '0;
    e3 = '0;
    for (int i = 0; i < 1500; i++) begin
      v = 10'($urandom);
      iv = $urandom_range(0, 3) != 0;
      ordy = $urandom_range(0, 3) != 0;
      drive3(v); if3.InValidxSI = iv; if3.OutReadyxSI = ordy;
      #1;
      mrdy = !m_ov3 || ordy;
      check("r3_rdy", 64'(if3.InReadyxSO), 64'(mrdy));
      if (iv && mrdy) begin
        m3 = adv(m3, nr(3), b);
        e3 = model_out(v, b, 3);
        pv3 = v;
        m_ov3 = 1'b1;
      end else if (ordy) m_ov3 = 1'b0;
      step();
      check("r3_ov", 64'(if3.OutValidxSO), 64'(m_ov3));
      if (m_ov3) check_vec("r3", obs3(), e3, pv3, 3);
    end
`ifdef DOM_ENC_UNMASK_CHECK_EN
    check("err2", 64'(if2.ErrxSO), 64'd0);
    check("err3", 64'(if3.ErrxSO), 64'd0);
`endif
    // reset with an output pending on dut2
    if3.InValidxSI = 1'b0;
    check("pre_rst_ov", 64'(if2.OutValidxSO), 64'd1);
    rst = 1'b1;
    step();
    check("mid_rst_ov", 64'(if2.OutValidxSO), 64'd0);
    check("mid_rst_rdy", 64'(if2.InReadyxSO), 64'd0);
    e2 = obs2();
    for (int i = 0; i < 10; i++) check($sformatf("mid_rst_bus%0d", i), e2[i], 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
